// File: rtl/painel_pkg.sv
// Shared types and helpers for the call panel: FSM encoding, travel direction, floor one-hot.
package painel_pkg;

  localparam int unsigned FLOOR_W    = 3;
  localparam int unsigned MAX_FLOORS = 8;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ISSUE       = 3'd1,
    ST_WAIT_START  = 3'd2,
    ST_WAIT_ARRIVE = 3'd3,
    ST_DOOR_OPEN   = 3'd4
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Full 8-bit one-hot; callers truncate to their floor count, so out-of-range floors map to zero.
  function automatic logic [MAX_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] idx);
    onehot = MAX_FLOORS'(1) << idx;
  endfunction

endpackage

// File: rtl/painel_scheduler.sv
// SCAN scheduler: nearest pending floor in the travel direction, reversing when nothing lies ahead.
module painel_scheduler
  import painel_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = 5
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    andar_atual,
  input  logic                  dir,
  output logic [FLOOR_W-1:0]    target,
  output logic                  new_dir,
  output logic                  valid
);

  logic [FLOOR_W-1:0] above;
  logic [FLOOR_W-1:0] below;
  logic               has_above;
  logic               has_below;

  always_comb begin
    above     = '0;
    below     = '0;
    has_above = 1'b0;
    has_below = 1'b0;
    // Scan downward so the last hit is the closest floor above.
    for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
      if (pending[i] && (FLOOR_W'(i) > andar_atual)) begin
        above     = FLOOR_W'(i);
        has_above = 1'b1;
      end
    end
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (pending[i] && (FLOOR_W'(i) < andar_atual)) begin
        below     = FLOOR_W'(i);
        has_below = 1'b1;
      end
    end
  end

  always_comb begin
    target  = '0;
    new_dir = dir;
    valid   = has_above | has_below;
    if (dir == DIR_UP) begin
      if (has_above) begin
        target = above;
      end else if (has_below) begin
        target  = below;
        new_dir = DIR_DOWN;
      end
    end else begin
      if (has_below) begin
        target = below;
      end else if (has_above) begin
        target  = above;
        new_dir = DIR_UP;
      end
    end
  end

endmodule

// File: rtl/painel_chamadas.sv
// Call panel and dispatcher: latches button presses, issues one held floor request at a time,
// detects arrival and runs the timed door phase.
module painel_chamadas
  import painel_pkg::*;
#(
  parameter int unsigned NUM_FLOORS    = 5,
  parameter int unsigned DOOR_CYCLES   = 4,
  parameter int unsigned START_TIMEOUT = 8,
  parameter int unsigned MAX_PEOPLE    = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] hall_btn,
  input  logic [NUM_FLOORS-1:0] cab_btn,
  input  logic [2:0]            andar_atual,
  input  logic                  busy,
  input  logic [3:0]            num_people,
  output logic [NUM_FLOORS-1:0] req,
  output logic                  door_open,
  output logic                  overload,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  error
);

  localparam int unsigned DWELL_W = $clog2(DOOR_CYCLES + 1);
  localparam int unsigned TMO_W   = $clog2(START_TIMEOUT + 1);

  state_t                  state_q, state_d;
  logic [NUM_FLOORS-1:0]   req_d, pending_d;
  logic                    door_d, error_d;
  logic                    dir_q, dir_d;
  logic [FLOOR_W-1:0]      target_q, target_d;
  logic [DWELL_W-1:0]      dwell_q, dwell_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;

  logic [NUM_FLOORS-1:0]   press, cur_oh, tgt_oh;
  logic [FLOOR_W-1:0]      sched_target;
  logic                    sched_dir, sched_valid;

  painel_scheduler #(.NUM_FLOORS(NUM_FLOORS)) u_scheduler (
    .pending     (pending),
    .andar_atual (andar_atual),
    .dir         (dir_q),
    .target      (sched_target),
    .new_dir     (sched_dir),
    .valid       (sched_valid)
  );

  assign overload = (num_people > 4'(MAX_PEOPLE));
  assign press    = hall_btn | cab_btn;
  assign cur_oh   = NUM_FLOORS'(onehot(andar_atual));
  assign tgt_oh   = NUM_FLOORS'(onehot(target_q));

  always_comb begin
    state_d   = state_q;
    req_d     = req;
    pending_d = pending | press;
    error_d   = error;
    dir_d     = dir_q;
    target_d  = target_q;
    dwell_d   = dwell_q;
    tmo_d     = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (|(pending & cur_oh)) begin
          pending_d = pending_d & ~cur_oh;
          dwell_d   = DWELL_W'(DOOR_CYCLES);
          state_d   = ST_DOOR_OPEN;
        end else if (sched_valid) begin
          target_d = sched_target;
          dir_d    = sched_dir;
          req_d    = NUM_FLOORS'(onehot(sched_target));
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (busy) begin
          state_d = ST_WAIT_ARRIVE;
        end else if (tmo_q == TMO_W'(START_TIMEOUT - 1)) begin
          // Call stays pending so IDLE retries it.
          error_d = 1'b1;
          req_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_WAIT_ARRIVE: begin
        if (!busy && (andar_atual == target_q)) begin
          req_d     = '0;
          pending_d = pending_d & ~tgt_oh;
          dwell_d   = DWELL_W'(DOOR_CYCLES);
          state_d   = ST_DOOR_OPEN;
        end
      end
      ST_DOOR_OPEN: begin
        // A press at the open floor extends the stop instead of queuing a call.
        pending_d = pending | (press & ~cur_oh);
        if (|(press & cur_oh)) begin
          dwell_d = DWELL_W'(DOOR_CYCLES);
        end else if (!overload) begin
          if (dwell_q <= DWELL_W'(1)) begin
            dwell_d = '0;
            state_d = ST_IDLE;
          end else begin
            dwell_d = dwell_q - DWELL_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    door_d = (state_d == ST_DOOR_OPEN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      req       <= '0;
      door_open <= 1'b0;
      pending   <= '0;
      error     <= 1'b0;
      dir_q     <= DIR_UP;
      target_q  <= '0;
      dwell_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      req       <= req_d;
      door_open <= door_d;
      pending   <= pending_d;
      error     <= error_d;
      dir_q     <= dir_d;
      target_q  <= target_d;
      dwell_q   <= dwell_d;
      tmo_q     <= tmo_d;
    end
  end

endmodule
